// File: rtl/ca_pkg.sv
// Shared definitions for the VGA cellular-automaton datapath: mode encoding,
// the rule table, geometry constants and the rule-to-colour mapping.
package ca_pkg;

    localparam int CELL_LOG       = 2;
    localparam int ROWS_PER_FRAME = 480 >> CELL_LOG;

    typedef enum logic [1:0] {
        MODE_AUTO   = 2'd0,
        MODE_STEP   = 2'd1,
        MODE_EXT    = 2'd2,
        MODE_FREEZE = 2'd3
    } mode_e;

    localparam logic [7:0] RULE_TABLE [8] = '{
        8'd30, 8'd110, 8'd22, 8'd73, 8'd90, 8'd146, 8'd105, 8'd102
    };

    // Display colour {R,G,B}, 2 bits each, taken from the middle rule bits.
    function automatic logic [5:0] rule_color_of(input logic [7:0] rule_in);
        return rule_in[6:1];
    endfunction

endpackage

// File: rtl/frame_debounce.sv
// Button conditioner: 2-flop synchroniser, one sample per frame, and a single
// press pulse when the sampled level goes 0 -> 1 -> 1 over three frames.
module frame_debounce (
    input  logic clk,
    input  logic rst_n,
    input  logic i_frame_start,
    input  logic i_btn,
    output logic o_press
);

    logic       r_sync1;
    logic       r_sync2;
    logic [1:0] r_hist;
    logic       r_press;

    // Synchronise, sample on frame_start, emit a one-cycle press pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 2'b00;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (i_frame_start) begin
                r_hist  <= {r_hist[0], r_sync2};
                r_press <= !r_hist[1] && r_hist[0] && r_sync2;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/ca_rule_sched.sv
// Rule scheduler and run controller: selects the per-row rule (auto scroll,
// manual step, external entry or freeze) and the per-frame seed/advance control.
module ca_rule_sched #(
    parameter int ROWS_PER_FRAME = 120,
    parameter int BAND_LOG       = 8,
    parameter int NRULES_LOG     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  row_tick,
    input  logic [1:0]            mode,
    input  logic                  btn_next,
    input  logic                  btn_seed,
    input  logic [7:0]            rule_ext,
    output logic [7:0]            rule,
    output logic [5:0]            rule_color,
    output logic                  seed_now,
    output logic                  advance_en,
    output logic [NRULES_LOG-1:0] table_idx
);

    localparam logic [10:0] RPF = 11'(ROWS_PER_FRAME);

    logic [1:0]            r_mode_s1;
    logic [1:0]            r_mode_s2;
    ca_pkg::mode_e         r_state;
    ca_pkg::mode_e         w_state_nxt;
    logic [10:0]           r_row_acc;
    logic [10:0]           w_acc_nxt;
    logic [NRULES_LOG-1:0] r_idx;
    logic [NRULES_LOG-1:0] w_idx_nxt;
    logic [7:0]            r_rule;
    logic [7:0]            w_rule_nxt;
    logic                  r_seed_now;
    logic                  r_adv;
    logic                  r_init;
    logic                  r_seed_pend;
    logic                  r_next_pend;
    logic                  w_seed_set;
    logic                  w_adv_nxt;
    logic                  w_press_next;
    logic                  w_press_seed;

    frame_debounce u_db_next (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_frame_start (frame_start),
        .i_btn         (btn_next),
        .o_press       (w_press_next)
    );

    frame_debounce u_db_seed (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_frame_start (frame_start),
        .i_btn         (btn_seed),
        .o_press       (w_press_seed)
    );

    // Two-flop synchroniser for the asynchronous mode switch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode_s1 <= 2'd0;
            r_mode_s2 <= 2'd0;
        end else begin
            r_mode_s1 <= mode;
            r_mode_s2 <= r_mode_s1;
        end
    end

    // Row accumulator: frame_start nets +1 per frame so the bands scroll; a
    // coincident row_tick adds its +1 on top.
    always_comb begin
        w_acc_nxt = r_row_acc;
        if (frame_start) w_acc_nxt = r_row_acc + 11'd1 - RPF;
        if (row_tick)    w_acc_nxt = w_acc_nxt + 11'd1;
    end

    // Mode state register; it only ever moves at a frame boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ca_pkg::MODE_AUTO;
        else        r_state <= w_state_nxt;
    end

    // Next state, next rule/index and next seed/advance flags.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_rule_nxt  = r_rule;
        if (frame_start) w_state_nxt = ca_pkg::mode_e'(r_mode_s2);
        if (frame_start || row_tick) begin
            case (w_state_nxt)
                ca_pkg::MODE_AUTO: begin
                    w_idx_nxt  = w_acc_nxt[BAND_LOG+NRULES_LOG-1:BAND_LOG];
                    w_rule_nxt = ca_pkg::RULE_TABLE[w_idx_nxt];
                end
                ca_pkg::MODE_STEP: begin
                    if (frame_start) begin
                        w_idx_nxt  = r_idx + NRULES_LOG'(r_next_pend | w_press_next);
                        w_rule_nxt = ca_pkg::RULE_TABLE[w_idx_nxt];
                    end
                end
                ca_pkg::MODE_EXT: begin
                    if (frame_start) w_rule_nxt = rule_ext;
                end
                default: begin
                    w_idx_nxt  = r_idx;
                    w_rule_nxt = r_rule;
                end
            endcase
        end
        w_seed_set = r_init | r_seed_pend | w_press_seed;
        w_adv_nxt  = (w_state_nxt != ca_pkg::MODE_FREEZE) | w_seed_set;
    end

    // Control registers: accumulator, rule outputs, seed queue and flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_row_acc   <= 11'd0;
            r_idx       <= '0;
            r_rule      <= ca_pkg::RULE_TABLE[0];
            r_seed_now  <= 1'b0;
            r_adv       <= 1'b0;
            r_init      <= 1'b1;
            r_seed_pend <= 1'b0;
            r_next_pend <= 1'b0;
        end else begin
            r_row_acc <= w_acc_nxt;
            r_idx     <= w_idx_nxt;
            r_rule    <= w_rule_nxt;
            if (frame_start) begin
                r_seed_now  <= w_seed_set;
                r_adv       <= w_adv_nxt;
                r_init      <= 1'b0;
                r_seed_pend <= 1'b0;
                r_next_pend <= 1'b0;
            end else begin
                if (w_press_seed) r_seed_pend <= 1'b1;
                if (w_press_next) r_next_pend <= 1'b1;
            end
        end
    end

    assign rule       = r_rule;
    assign rule_color = ca_pkg::rule_color_of(r_rule);
    assign seed_now   = r_seed_now;
    assign advance_en = r_adv;
    assign table_idx  = r_idx;

endmodule
